wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; register count is 2^ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port RegWrite_in  input  1  write-back enable from the MEM-WB pipelined register.
REQ-006 SHALL have port MemtoReg_in  input  1  1 selects MemData_in, 0 selects ALUData_in.
REQ-007 SHALL have port MemData_in  input  DATA_W  load data from the MEM-WB pipelined register.
REQ-008 SHALL have port ALUData_in  input  DATA_W  ALU result from the MEM-WB pipelined register.
REQ-009 SHALL have port WBregister_in  input  ADDR_W  destination register number.
REQ-010 SHALL have port RSaddr_in  input  ADDR_W  decode-stage read port A address.
REQ-011 SHALL have port RTaddr_in  input  ADDR_W  decode-stage read port B address.
REQ-012 SHALL have port RSdata_out  output  DATA_W  read port A data.
REQ-013 SHALL have port RTdata_out  output  DATA_W  read port B data.
REQ-014 SHALL have port WBdata_out  output  DATA_W  selected write-back value, for the forwarding unit.
REQ-015 SHALL have port WBvalid_out  output  1  high when the current write-back is architecturally effective.
REQ-016 SHALL have port dbg_addr_in  input  ADDR_W  debug read address.
REQ-017 SHALL have port dbg_data_out  output  DATA_W  debug read data (storage only, no bypass).
REQ-018 SHALL have port wb_count_out  output  32  count of effective write-backs since reset.

Function
REQ-019 WBdata_out SHALL equal MemtoReg_in ? MemData_in : ALUData_in, combinationally.
REQ-020 WBvalid_out SHALL equal RegWrite_in AND (WBregister_in != 0), combinationally.
REQ-021 On a rising edge with WBvalid_out high and rst low, register[WBregister_in] SHALL take WBdata_out.
REQ-022 Register 0 SHALL never be written; reads of address 0 on any port SHALL return 0.
REQ-023 Read ports SHALL be combinational (zero latency) from storage.
REQ-024 Write-to-read bypass: when WBvalid_out is high and RSaddr_in == WBregister_in, RSdata_out SHALL equal WBdata_out in the same cycle; likewise for RTaddr_in/RTdata_out.
REQ-025 Both read ports addressing the bypassed register simultaneously SHALL both receive WBdata_out.
REQ-026 RegWrite_in low SHALL leave storage unchanged and disable bypass regardless of other inputs.
REQ-027 wb_count_out SHALL increment by 1 on each rising edge where WBvalid_out is high, wrapping from 0xFFFFFFFF to 0.
REQ-028 dbg_data_out SHALL reflect committed storage only; a write becomes visible on it the cycle after the edge.

Reset
REQ-029 While rst is high at a rising edge, all registers and wb_count_out SHALL clear to 0 and any concurrent write SHALL be dropped.
REQ-030 During reset, read and WB outputs SHALL remain combinational functions of inputs and cleared storage; no output is itself reset-registered except wb_count_out.
REQ-031 Reset asserted mid-stream SHALL take effect at the next edge; the first write after rst deasserts SHALL commit normally.

Structure
REQ-032 DATA_W/ADDR_W defaults and the zero-register constant SHALL live in the shared CPU package.
REQ-033 Storage SHALL be one sub-module, regfile_core (1 sync write port, 3 async read ports, no bypass); write-back select, bypass, and counter SHALL be in wb_regfile.

Verification
REQ-034 Reset, then read all 32 addresses on RS, RT, debug -> all 0; wb_count_out = 0.
REQ-035 RegWrite=1, MemtoReg=0, ALU=0x12345678, WB=5, RS=5 -> RSdata_out = 0x12345678 same cycle; dbg_addr 5 shows it next cycle; count = 1.
REQ-036 RegWrite=1, MemtoReg=1, Mem=0xDEADBEEF, ALU=0x1, WB=0 -> WBvalid_out=0, reg0 reads 0, count unchanged.
REQ-037 RegWrite=0, WB=7, RS=RT=7, ALU=0xAAAA5555 -> ports return prior reg7 value; storage unchanged.
REQ-038 rst=1 in the same cycle as a write of 0xCAFEF00D to reg 9 -> reg9 = 0 afterwards; count = 0.
REQ-039 Preload count 0xFFFFFFFF (force), one valid write -> count = 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared CPU constants for the write-back register file.
package wb_regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;
    localparam int CNT_W      = 32;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM-WB write-back, decode read ports and debug/status bundle.
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              RegWrite_in;
    logic              MemtoReg_in;
    logic [DATA_W-1:0] MemData_in;
    logic [DATA_W-1:0] ALUData_in;
    logic [ADDR_W-1:0] WBregister_in;
    logic [ADDR_W-1:0] RSaddr_in;
    logic [ADDR_W-1:0] RTaddr_in;
    logic [DATA_W-1:0] RSdata_out;
    logic [DATA_W-1:0] RTdata_out;
    logic [DATA_W-1:0] WBdata_out;
    logic              WBvalid_out;
    logic [ADDR_W-1:0] dbg_addr_in;
    logic [DATA_W-1:0] dbg_data_out;
    logic [CNT_W-1:0]  wb_count_out;

    modport master (
        output RegWrite_in, MemtoReg_in, MemData_in, ALUData_in, WBregister_in,
        output RSaddr_in, RTaddr_in, dbg_addr_in,
        input  RSdata_out, RTdata_out, WBdata_out, WBvalid_out, dbg_data_out, wb_count_out
    );

    modport slave (
        input  RegWrite_in, MemtoReg_in, MemData_in, ALUData_in, WBregister_in,
        input  RSaddr_in, RTaddr_in, dbg_addr_in,
        output RSdata_out, RTdata_out, WBdata_out, WBvalid_out, dbg_data_out, wb_count_out
    );
endinterface

// File: rtl/wb_regfile_core.sv
// regfile_core: 2^ADDR_W x DATA_W storage, one sync write port, three async read ports.
// Address 0 is hardwired to zero on every read and never written.
module regfile_core
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_ra_addr,
    input  logic [ADDR_W-1:0] i_rb_addr,
    input  logic [ADDR_W-1:0] i_rc_addr,
    output logic [DATA_W-1:0] o_ra_data,
    output logic [DATA_W-1:0] o_rb_data,
    output logic [DATA_W-1:0] o_rc_data
);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
        end else if (i_we && i_waddr != ZERO_A) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_data = (i_ra_addr == ZERO_A) ? '0 : r_mem[i_ra_addr];
    assign o_rb_data = (i_rb_addr == ZERO_A) ? '0 : r_mem[i_rb_addr];
    assign o_rc_data = (i_rc_addr == ZERO_A) ? '0 : r_mem[i_rc_addr];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, write-to-read bypass and effective-write counter
// around regfile_core storage.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_valid;
    logic [DATA_W-1:0] w_rs_mem;
    logic [DATA_W-1:0] w_rt_mem;
    logic [CNT_W-1:0]  r_wb_count;

    assign w_wb_data  = bus.MemtoReg_in ? bus.MemData_in : bus.ALUData_in;
    assign w_wb_valid = bus.RegWrite_in && (bus.WBregister_in != ZERO_A);

    regfile_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_wb_valid),
        .i_waddr   (bus.WBregister_in),
        .i_wdata   (w_wb_data),
        .i_ra_addr (bus.RSaddr_in),
        .i_rb_addr (bus.RTaddr_in),
        .i_rc_addr (bus.dbg_addr_in),
        .o_ra_data (w_rs_mem),
        .o_rb_data (w_rt_mem),
        .o_rc_data (bus.dbg_data_out)
    );

    // Valid already excludes register 0, so bypass can never leak into address 0.
    assign bus.RSdata_out   = (w_wb_valid && bus.RSaddr_in == bus.WBregister_in) ? w_wb_data : w_rs_mem;
    assign bus.RTdata_out   = (w_wb_valid && bus.RTaddr_in == bus.WBregister_in) ? w_wb_data : w_rt_mem;
    assign bus.WBdata_out   = w_wb_data;
    assign bus.WBvalid_out  = w_wb_valid;
    assign bus.wb_count_out = r_wb_count;

    always_ff @(posedge clk) begin
        if (rst) r_wb_count <= '0;
        else if (w_wb_valid) r_wb_count <= r_wb_count + 1'b1;
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scenarios plus randomized traffic against an array-based
// model of the register file, write-back mux, bypass and write counter.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_regfile_if bus ();
    wb_regfile dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] m_regs [32];
    logic [31:0] m_count;
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input bit r, input bit we, input bit m2r, input logic [31:0] md,
                         input logic [31:0] ad, input logic [4:0] wb, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] dbg);
        rst = r;
        bus.RegWrite_in = we;
        bus.MemtoReg_in = m2r;
        bus.MemData_in = md;
        bus.ALUData_in = ad;
        bus.WBregister_in = wb;
        bus.RSaddr_in = rs;
        bus.RTaddr_in = rt;
        bus.dbg_addr_in = dbg;
    endtask

    function automatic logic [31:0] m_wbdata();
        return bus.MemtoReg_in ? bus.MemData_in : bus.ALUData_in;
    endfunction

    function automatic bit m_valid();
        return bus.RegWrite_in && bus.WBregister_in != 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (m_valid() && a == bus.WBregister_in) return m_wbdata();
        return m_regs[a];
    endfunction

    task automatic check_comb();
        check("wbdata", bus.WBdata_out, m_wbdata());
        check("wbvalid", 32'(bus.WBvalid_out), 32'(m_valid()));
        check("rs", bus.RSdata_out, m_read(bus.RSaddr_in));
        check("rt", bus.RTdata_out, m_read(bus.RTaddr_in));
        check("dbg", bus.dbg_data_out, m_regs[bus.dbg_addr_in]);
        check("count", bus.wb_count_out, m_count);
    endtask

    task automatic tick();
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_count = '0;
        end else if (m_valid()) begin
            m_regs[bus.WBregister_in] = m_wbdata();
            m_count = m_count + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_count = '0;
        @(negedge clk);
        drive(1, 1, 0, 32'h0, 32'h5A5A5A5A, 5'd3, 5'd0, 5'd0, 5'd0);
        tick();
        tick();

        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(a), 5'(a), 5'(a), 5'(a));
            #1;
            check("rst_rs", bus.RSdata_out, 32'h0);
            check("rst_rt", bus.RTdata_out, 32'h0);
            check("rst_dbg", bus.dbg_data_out, 32'h0);
        end
        check("rst_count", bus.wb_count_out, 32'h0);

        drive(0, 1, 0, 32'h0, 32'h12345678, 5'd5, 5'd5, 5'd0, 5'd5);
        #1;
        check("byp_rs", bus.RSdata_out, 32'h12345678);
        check("dbg_pre", bus.dbg_data_out, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd5);
        #1;
        check("dbg_post", bus.dbg_data_out, 32'h12345678);
        check("count1", bus.wb_count_out, 32'd1);

        drive(0, 1, 1, 32'hDEADBEEF, 32'h1, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("r0_valid", 32'(bus.WBvalid_out), 32'd0);
        check("r0_wbdata", bus.WBdata_out, 32'hDEADBEEF);
        check("r0_rs", bus.RSdata_out, 32'h0);
        tick();
        #1;
        check("r0_dbg", bus.dbg_data_out, 32'h0);
        check("r0_count", bus.wb_count_out, 32'd1);

        drive(0, 1, 1, 32'h11112222, 32'h0, 5'd7, 5'd0, 5'd0, 5'd7);
        tick();
        drive(0, 0, 0, 32'h0, 32'hAAAA5555, 5'd7, 5'd7, 5'd7, 5'd7);
        #1;
        check("nowe_rs", bus.RSdata_out, 32'h11112222);
        check("nowe_rt", bus.RTdata_out, 32'h11112222);
        tick();
        #1;
        check("nowe_dbg", bus.dbg_data_out, 32'h11112222);
        check("nowe_count", bus.wb_count_out, 32'd2);

        drive(0, 1, 0, 32'h0, 32'h99887766, 5'd12, 5'd12, 5'd12, 5'd0);
        #1;
        check("dual_rs", bus.RSdata_out, 32'h99887766);
        check("dual_rt", bus.RTdata_out, 32'h99887766);
        tick();

        drive(1, 1, 0, 32'h0, 32'hCAFEF00D, 5'd9, 5'd9, 5'd0, 5'd9);
        #1;
        check("rstw_byp", bus.RSdata_out, 32'hCAFEF00D);
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd9);
        #1;
        check("rstw_dbg", bus.dbg_data_out, 32'h0);
        check("rstw_count", bus.wb_count_out, 32'h0);
        drive(0, 1, 0, 32'h0, 32'h00000055, 5'd9, 5'd0, 5'd0, 5'd9);
        tick();
        #1;
        check("post_rst_dbg", bus.dbg_data_out, 32'h55);
        check("post_rst_count", bus.wb_count_out, 32'd1);

        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        force dut.r_wb_count = 32'hFFFFFFFF;
        #1;
        release dut.r_wb_count;
        m_count = 32'hFFFFFFFF;
        #1;
        check("wrap_pre", bus.wb_count_out, 32'hFFFFFFFF);
        drive(0, 1, 0, 32'h0, 32'h3, 5'd4, 5'd0, 5'd0, 5'd0);
        tick();
        #1;
        check("wrap_post", bus.wb_count_out, 32'h0);

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) bus.RSaddr_in = bus.WBregister_in;
            if ($urandom_range(0, 3) == 0) bus.RTaddr_in = bus.WBregister_in;
            #1;
            check_comb();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
